tiling: RTL and testbench
=========================

TILING -- requirements
Module: tiling

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, byte-address width of all DRAM/GLB addresses; DATA_WIDTH, default 8, element width (memory word = 4*DATA_WIDTH = 32 bits).
REQ-002 One clock; reset is synchronous and active-low: clk input 1, rising-edge clock; rst input 1, synchronous active-low reset.
REQ-003 start input 1; one-cycle request to process one layer tile.
REQ-004 finish output 1; one-cycle completion pulse.
REQ-005 mapping_param input 32; PE-mapping word, captured on start, no functional effect.
REQ-006 shape_param1 input 32; [9:0] M filters, [15:10] C channels, [19:18] R=S kernel size, [25:24] U stride; other bits ignored.
REQ-007 shape_param2 input 32; [7:0] W ifmap width, [15:8] H ifmap height; other bits ignored.
REQ-008 dram_ifmap/filter/bias/opsum_base_addr inputs ADDR_WIDTH each; DRAM byte base addresses.
REQ-009 glb_ifmap/filter/bias/opsum_base_addr inputs ADDR_WIDTH each; GLB byte base addresses.
REQ-010 dram_we output 1, dram_addr output ADDR_WIDTH, dram_w_data output 32, dram_r_data input 32; one shared DRAM port, little-endian, read data valid one cycle after the address.
REQ-011 glb_r_addr output ADDR_WIDTH, glb_r_data input 32 (one-cycle read latency); glb_we output 1, glb_w_addr output ADDR_WIDTH, glb_w_data output 32.

Function
REQ-012 Derived: E=(H-R)/U+1, F=(W-R)/U+1, integer division; all shape values captured into registers on accepted start.
REQ-013 start accepted only in IDLE; ignored in every other state.
REQ-014 States: IDLE -> LOAD_IF -> LOAD_FLT -> LOAD_BIAS -> COMPUTE -> STORE -> DONE -> IDLE.
REQ-015 LOAD_IF: copies ceil(H*W*C/4) 32-bit words DRAM ifmap base -> GLB ifmap base, word i at byte offset 4i; GLB write issued the cycle after the DRAM read returns.
REQ-016 LOAD_FLT: same copy for ceil(M*R*R*C/4) words; LOAD_BIAS: M words.
REQ-017 Layouts: ifmap byte (h*W+w)*C+c; filter byte ((m*R+r)*R+s)*C+c; bias word m; opsum word (e*F+f)*M+m.
REQ-018 ifmap and filter elements are signed 8-bit; bias and opsum are signed 32-bit two's complement; no saturation, activation or requantization.
REQ-019 COMPUTE: for each (e,f,m) in that nesting order: acc = bias[m] + sum over r,s,c of ifmap[e*U+r][f*U+s][c] * filter[m][r][s][c]; elements fetched from GLB by byte address, operand = glb_r_data[7:0].
REQ-020 Each finished acc written to GLB opsum base + 4*((e*F+f)*M+m) with glb_we high for exactly one cycle.
REQ-021 STORE: copies E*F*M words from GLB opsum base to DRAM opsum base, word by word, dram_we high one cycle per word.
REQ-022 dram_we and glb_we are 0 in every state except the write cycles above; dram_we never coincides with a DRAM read needed for the current transfer.
REQ-023 DONE lasts one cycle: finish=1, then IDLE; finish is 0 in every other state.
REQ-024 A new start after finish reruns the full sequence; identical inputs yield identical GLB/DRAM results.
REQ-025 Zero-size fields (M, C, R, H or W = 0) skip the affected phases; the block still reaches DONE and pulses finish.

Reset
REQ-026 While rst=0 at a rising edge: state IDLE; finish, dram_we, glb_we = 0; all addresses, write data, counters and the accumulator = 0.
REQ-027 Reset mid-operation aborts immediately; no further writes; partial GLB/DRAM contents left as written.

Verification
REQ-028 Layer H=W=34, C=6, M=8, R=3, U=2 (shape_param1=0x024C1808, shape_param2=0x00002222, mapping_param=0x000480D9), DRAM bases 0/4096/8192/12288, GLB bases 0/2048/4096/6144 -> finish pulses once; all 16*16*8 GLB opsum words match the software conv model.
REQ-029 Same layer started 10 times back-to-back -> 10 finish pulses, identical results each time; starts during busy ignored.
REQ-030 Ifmap all -128, filter all -128, bias 0, C=1, R=1 -> every opsum word = 16384.
REQ-031 After finish -> DRAM opsum region equals GLB opsum region word for word; GLB ifmap/filter/bias regions equal their DRAM sources.
REQ-032 rst=0 asserted mid-COMPUTE -> next cycle all outputs 0, no writes; new start completes correctly.
REQ-033 M=0 -> finish pulses; no opsum writes to GLB or DRAM.

Source files
------------

// File: rtl/tiling.sv
// Single-layer convolution tile engine: stages ifmap/filter/bias from DRAM
// into the GLB, runs a sequential MAC over every output, writes opsums to the
// GLB and finally copies the opsum region back to DRAM.
module tiling #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  finish,
  input  logic [31:0]           mapping_param,
  input  logic [31:0]           shape_param1,
  input  logic [31:0]           shape_param2,
  input  logic [ADDR_WIDTH-1:0] dram_ifmap_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_filter_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_bias_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_opsum_base_addr,
  input  logic [ADDR_WIDTH-1:0] glb_ifmap_base_addr,
  input  logic [ADDR_WIDTH-1:0] glb_filter_base_addr,
  input  logic [ADDR_WIDTH-1:0] glb_bias_base_addr,
  input  logic [ADDR_WIDTH-1:0] glb_opsum_base_addr,
  output logic                  dram_we,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [31:0]           dram_w_data,
  input  logic [31:0]           dram_r_data,
  output logic [ADDR_WIDTH-1:0] glb_r_addr,
  input  logic [31:0]           glb_r_data,
  output logic                  glb_we,
  output logic [ADDR_WIDTH-1:0] glb_w_addr,
  output logic [31:0]           glb_w_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD_IF, LOAD_FLT, LOAD_BIAS, COMPUTE, STORE, DONE
  } state_t;

  // Per-word micro-steps: ADDR/WAIT/TAKE serve copies and the bias fetch;
  // the IF_/FLT_/MAC steps form one multiply-accumulate.
  typedef enum logic [3:0] {
    STEP_ADDR, STEP_WAIT, STEP_TAKE,
    STEP_IF_ADDR, STEP_IF_WAIT, STEP_FLT_ADDR, STEP_FLT_WAIT, STEP_MAC,
    STEP_WRITE
  } step_t;

  state_t state;
  step_t  step;

  logic [31:0] mapping_q;
  logic [9:0]  m_q;
  logic [5:0]  c_q;
  logic [1:0]  r_q, u_q;
  logic [7:0]  w_q, h_q;

  logic [7:0]  ce, cf;
  logic [9:0]  cm;
  logic [1:0]  cr, cs;
  logic [5:0]  cc;
  logic [31:0] idx;
  logic signed [31:0]           acc;
  logic signed [DATA_WIDTH-1:0] ifv;

  logic                  shape_ok;
  logic [7:0]            e_dim, f_dim;
  logic [31:0]           out_total, if_words, flt_words;
  logic [31:0]           cp_cnt, if_off, flt_off, h_pos, w_pos;
  logic [ADDR_WIDTH-1:0] cp_src, cp_dst, word_off;
  state_t                cp_next;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                  unused_bits;

  assign unused_bits = ^{mapping_q, shape_param1[31:26], shape_param1[23:20],
                         shape_param1[17:16], shape_param2[31:16]};

  function automatic logic [7:0] span_div(input logic [7:0] span, input logic [1:0] u);
    case (u)
      2'd1:    span_div = span;
      2'd2:    span_div = span >> 1;
      2'd3:    span_div = span / 8'd3;
      default: span_div = '0;
    endcase
  endfunction

  // Derived layer geometry, per-phase copy source/destination and MAC operands
  always_comb begin
    // Any zero-sized field, zero stride or kernel wider than the ifmap makes
    // the output volume empty, so COMPUTE and STORE fall straight through.
    shape_ok  = (m_q != '0) && (c_q != '0) && (r_q != '0) && (u_q != '0) &&
                (h_q >= 8'(r_q)) && (w_q >= 8'(r_q));
    e_dim     = shape_ok ? span_div(h_q - 8'(r_q), u_q) + 8'd1 : '0;
    f_dim     = shape_ok ? span_div(w_q - 8'(r_q), u_q) + 8'd1 : '0;
    out_total = 32'(e_dim) * 32'(f_dim) * 32'(m_q);
    if_words  = (32'(h_q) * 32'(w_q) * 32'(c_q) + 32'd3) >> 2;
    flt_words = (32'(m_q) * 32'(r_q) * 32'(r_q) * 32'(c_q) + 32'd3) >> 2;
    word_off  = ADDR_WIDTH'({idx, 2'b00});

    cp_cnt  = '0;
    cp_src  = '0;
    cp_dst  = '0;
    cp_next = IDLE;
    case (state)
      LOAD_IF: begin
        cp_cnt = if_words;  cp_src = dram_ifmap_base_addr;
        cp_dst = glb_ifmap_base_addr;  cp_next = LOAD_FLT;
      end
      LOAD_FLT: begin
        cp_cnt = flt_words; cp_src = dram_filter_base_addr;
        cp_dst = glb_filter_base_addr; cp_next = LOAD_BIAS;
      end
      LOAD_BIAS: begin
        cp_cnt = 32'(m_q);  cp_src = dram_bias_base_addr;
        cp_dst = glb_bias_base_addr;   cp_next = COMPUTE;
      end
      STORE: begin
        cp_cnt = out_total; cp_src = glb_opsum_base_addr;
        cp_dst = dram_opsum_base_addr; cp_next = DONE;
      end
      default: ;
    endcase

    h_pos   = 32'(ce) * 32'(u_q) + 32'(cr);
    w_pos   = 32'(cf) * 32'(u_q) + 32'(cs);
    if_off  = (h_pos * 32'(w_q) + w_pos) * 32'(c_q) + 32'(cc);
    flt_off = ((32'(cm) * 32'(r_q) + 32'(cr)) * 32'(r_q) + 32'(cs)) * 32'(c_q) + 32'(cc);
    prod    = ifv * $signed(glb_r_data[DATA_WIDTH-1:0]);
  end

  // Main sequencer: phase FSM with registered memory-port outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;  step <= STEP_ADDR;
      finish <= 1'b0; dram_we <= 1'b0; glb_we <= 1'b0;
      dram_addr <= '0; dram_w_data <= '0; glb_r_addr <= '0;
      glb_w_addr <= '0; glb_w_data <= '0;
      mapping_q <= '0; m_q <= '0; c_q <= '0; r_q <= '0; u_q <= '0;
      w_q <= '0; h_q <= '0;
      ce <= '0; cf <= '0; cm <= '0; cr <= '0; cs <= '0; cc <= '0;
      idx <= '0; acc <= '0; ifv <= '0;
    end else begin
      finish  <= 1'b0;
      dram_we <= 1'b0;
      glb_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mapping_q <= mapping_param;
            m_q <= shape_param1[9:0];   c_q <= shape_param1[15:10];
            r_q <= shape_param1[19:18]; u_q <= shape_param1[25:24];
            w_q <= shape_param2[7:0];   h_q <= shape_param2[15:8];
            ce <= '0; cf <= '0; cm <= '0; cr <= '0; cs <= '0; cc <= '0;
            idx <= '0; step <= STEP_ADDR; state <= LOAD_IF;
          end
        end
        LOAD_IF, LOAD_FLT, LOAD_BIAS, STORE: begin
          case (step)
            STEP_ADDR: begin
              if (idx >= cp_cnt) begin
                idx <= '0;
                state <= cp_next;
                finish <= (cp_next == DONE);
              end else begin
                if (state == STORE) glb_r_addr <= cp_src + word_off;
                else                dram_addr  <= cp_src + word_off;
                step <= STEP_WAIT;
              end
            end
            STEP_WAIT: step <= STEP_TAKE;
            STEP_TAKE: begin
              if (state == STORE) begin
                dram_we <= 1'b1; dram_addr <= cp_dst + word_off;
                dram_w_data <= glb_r_data;
              end else begin
                glb_we <= 1'b1; glb_w_addr <= cp_dst + word_off;
                glb_w_data <= dram_r_data;
              end
              idx  <= idx + 32'd1;
              step <= STEP_ADDR;
            end
            default: step <= STEP_ADDR;
          endcase
        end
        COMPUTE: begin
          case (step)
            STEP_ADDR: begin
              if (idx >= out_total) begin
                idx <= '0; state <= STORE;
              end else begin
                glb_r_addr <= glb_bias_base_addr + ADDR_WIDTH'({cm, 2'b00});
                step <= STEP_WAIT;
              end
            end
            STEP_WAIT:     step <= STEP_TAKE;
            STEP_TAKE:     begin acc <= glb_r_data; step <= STEP_IF_ADDR; end
            STEP_IF_ADDR:  begin
              glb_r_addr <= glb_ifmap_base_addr + ADDR_WIDTH'(if_off);
              step <= STEP_IF_WAIT;
            end
            STEP_IF_WAIT:  step <= STEP_FLT_ADDR;
            STEP_FLT_ADDR: begin
              ifv <= glb_r_data[DATA_WIDTH-1:0];
              glb_r_addr <= glb_filter_base_addr + ADDR_WIDTH'(flt_off);
              step <= STEP_FLT_WAIT;
            end
            STEP_FLT_WAIT: step <= STEP_MAC;
            STEP_MAC: begin
              acc  <= acc + 32'(prod);
              step <= STEP_IF_ADDR;
              if (cc == c_q - 6'd1) begin
                cc <= '0;
                if (cs == r_q - 2'd1) begin
                  cs <= '0;
                  if (cr == r_q - 2'd1) begin
                    cr <= '0; step <= STEP_WRITE;
                  end else cr <= cr + 2'd1;
                end else cs <= cs + 2'd1;
              end else cc <= cc + 6'd1;
            end
            STEP_WRITE: begin
              glb_we <= 1'b1;
              glb_w_addr <= glb_opsum_base_addr + word_off;
              glb_w_data <= acc;
              idx  <= idx + 32'd1;
              step <= STEP_ADDR;
              if (cm == m_q - 10'd1) begin
                cm <= '0;
                if (cf == f_dim - 8'd1) begin
                  cf <= '0; ce <= ce + 8'd1;
                end else cf <= cf + 8'd1;
              end else cm <= cm + 10'd1;
            end
            default: step <= STEP_ADDR;
          endcase
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiling.sv
// Directed bench for tiling: word-addressed DRAM/GLB models, a reference
// convolution over the bench's own operand arrays, and hand-computed layers.
module tb_tiling;

  localparam int DRAM_IF = 0,  DRAM_FLT = 4096, DRAM_BIAS = 8192, DRAM_OP = 12288;
  localparam int GLB_IF  = 0,  GLB_FLT  = 2048, GLB_BIAS  = 4096, GLB_OP  = 6144;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        finish, dram_we, glb_we;
  logic [31:0] mapping_param = 32'h000480D9, shape_param1 = '0, shape_param2 = '0;
  logic [31:0] dram_addr, dram_w_data, dram_r_data, glb_r_addr, glb_r_data;
  logic [31:0] glb_w_addr, glb_w_data;

  logic [31:0] dram_mem [0:4095];
  logic [31:0] glb_mem  [0:4095];
  logic        tb_we = 1'b0, tb_glb = 1'b0;
  logic [11:0] tb_idx = '0;
  logic [31:0] tb_data = '0;

  int n_chk = 0, n_err = 0;
  int fin_cnt = 0, gop_cnt = 0, dwr_cnt = 0;
  int L_H, L_W, L_C, L_M, L_R, L_U;
  byte if_b  [0:1023];
  byte flt_b [0:1023];
  int  bias_w [0:63];

  tiling #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .mapping_param(mapping_param), .shape_param1(shape_param1), .shape_param2(shape_param2),
    .dram_ifmap_base_addr(32'(DRAM_IF)), .dram_filter_base_addr(32'(DRAM_FLT)),
    .dram_bias_base_addr(32'(DRAM_BIAS)), .dram_opsum_base_addr(32'(DRAM_OP)),
    .glb_ifmap_base_addr(32'(GLB_IF)), .glb_filter_base_addr(32'(GLB_FLT)),
    .glb_bias_base_addr(32'(GLB_BIAS)), .glb_opsum_base_addr(32'(GLB_OP)),
    .dram_we(dram_we), .dram_addr(dram_addr), .dram_w_data(dram_w_data),
    .dram_r_data(dram_r_data), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
  );

  always #5 clk = ~clk;

  // Memory models: one-cycle read latency, GLB reads return the addressed byte in [7:0]
  always @(posedge clk) begin
    if (tb_we) begin
      if (tb_glb) glb_mem[tb_idx] <= tb_data;
      else        dram_mem[tb_idx] <= tb_data;
    end
    if (dram_we) dram_mem[dram_addr[13:2]] <= dram_w_data;
    if (glb_we)  glb_mem[glb_w_addr[13:2]] <= glb_w_data;
    dram_r_data <= dram_mem[dram_addr[13:2]];
    glb_r_data  <= glb_mem[glb_r_addr[13:2]] >> {glb_r_addr[1:0], 3'b000};
  end

  // Event counters sampled on the same edge the memories commit writes
  always @(posedge clk) begin
    if (finish) fin_cnt++;
    if (glb_we && glb_w_addr >= 32'(GLB_OP)) gop_cnt++;
    if (dram_we) dwr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tb_write(input bit to_glb, input int widx, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_glb = to_glb; tb_idx = 12'(widx); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic int dim(input int x);
    if (L_M == 0 || L_C == 0 || L_R == 0 || L_U == 0 || L_H < L_R || L_W < L_R) return 0;
    return (x - L_R) / L_U + 1;
  endfunction

  function automatic int n_out();
    return dim(L_H) * dim(L_W) * L_M;
  endfunction

  function automatic int ref_out(input int e, input int f, input int m);
    int acc;
    acc = bias_w[m];
    for (int r = 0; r < L_R; r++)
      for (int s = 0; s < L_R; s++)
        for (int c = 0; c < L_C; c++)
          acc += int'(if_b[((e*L_U + r)*L_W + f*L_U + s)*L_C + c]) *
                 int'(flt_b[((m*L_R + r)*L_R + s)*L_C + c]);
    return acc;
  endfunction

  // kind 0: patterned signed data, 1: all -128 with zero bias, 2: single hand value
  task automatic load_layer(input int h, input int w, input int c, input int m,
                            input int r, input int u, input int kind);
    int n_if, n_f;
    L_H = h; L_W = w; L_C = c; L_M = m; L_R = r; L_U = u;
    n_if = h*w*c; n_f = m*r*r*c;
    for (int i = 0; i < 1024; i++) begin
      if_b[i]  = (i < n_if) ? ((kind == 1) ? -8'sd128 : byte'(i*37 + 5)) : 8'sd0;
      flt_b[i] = (i < n_f)  ? ((kind == 1) ? -8'sd128 : byte'(i*53 - 20)) : 8'sd0;
    end
    for (int i = 0; i < 64; i++) bias_w[i] = (kind == 1) ? 0 : i*1000 - 1500;
    if (kind == 2) begin if_b[0] = 8'sd5; flt_b[0] = -8'sd3; bias_w[0] = 100; end
    for (int i = 0; i < (n_if+3)/4; i++)
      tb_write(1'b0, DRAM_IF/4 + i, {if_b[4*i+3], if_b[4*i+2], if_b[4*i+1], if_b[4*i]});
    for (int i = 0; i < (n_f+3)/4; i++)
      tb_write(1'b0, DRAM_FLT/4 + i, {flt_b[4*i+3], flt_b[4*i+2], flt_b[4*i+1], flt_b[4*i]});
    for (int i = 0; i < m; i++) tb_write(1'b0, DRAM_BIAS/4 + i, bias_w[i]);
  endtask

  task automatic set_shape();
    shape_param1 = 32'(L_M) | (32'(L_C) << 10) | (32'(L_R) << 18) | (32'(L_U) << 24) | 32'hC0F3_0000;
    shape_param2 = 32'(L_W) | (32'(L_H) << 8) | 32'h5A5A_0000;
  endtask

  task automatic clear_opsum();
    for (int i = 0; i < n_out(); i++) begin
      tb_write(1'b1, GLB_OP/4 + i, 32'hDEADBEEF);
      tb_write(1'b0, DRAM_OP/4 + i, 32'hDEADBEEF);
    end
  endtask

  task automatic wait_finish(input string tag, input int last);
    int waited = 0;
    while (fin_cnt == last && waited < 40000) begin @(negedge clk); waited++; end
    check({tag, "_finish_seen"}, 32'(fin_cnt != last), 32'd1);
  endtask

  task automatic run_layer(input string tag);
    int f0, g0, d0;
    clear_opsum();
    f0 = fin_cnt; g0 = gop_cnt; d0 = dwr_cnt;
    @(negedge clk); set_shape(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_finish(tag, f0);
    repeat (5) @(negedge clk);
    check({tag, "_finish_pulses"}, fin_cnt - f0, 32'd1);
    check({tag, "_glb_opsum_writes"}, gop_cnt - g0, n_out());
    check({tag, "_dram_writes"}, dwr_cnt - d0, n_out());
  endtask

  task automatic verify_op(input string tag);
    int k;
    for (int e = 0; e < dim(L_H); e++)
      for (int f = 0; f < dim(L_W); f++)
        for (int m = 0; m < L_M; m++) begin
          k = (e*dim(L_W) + f)*L_M + m;
          check($sformatf("%s_glb_op[%0d]", tag, k), glb_mem[GLB_OP/4 + k], ref_out(e, f, m));
          check($sformatf("%s_dram_op[%0d]", tag, k), dram_mem[DRAM_OP/4 + k], ref_out(e, f, m));
        end
  endtask

  task automatic verify_inputs(input string tag);
    for (int i = 0; i < (L_H*L_W*L_C+3)/4; i++)
      check($sformatf("%s_glb_if[%0d]", tag, i), glb_mem[GLB_IF/4 + i],
            {if_b[4*i+3], if_b[4*i+2], if_b[4*i+1], if_b[4*i]});
    for (int i = 0; i < (L_M*L_R*L_R*L_C+3)/4; i++)
      check($sformatf("%s_glb_flt[%0d]", tag, i), glb_mem[GLB_FLT/4 + i],
            {flt_b[4*i+3], flt_b[4*i+2], flt_b[4*i+1], flt_b[4*i]});
    for (int i = 0; i < L_M; i++)
      check($sformatf("%s_glb_bias[%0d]", tag, i), glb_mem[GLB_BIAS/4 + i], bias_w[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_finish"},      32'(finish), 32'd0);
    check({tag, "_dram_we"},     32'(dram_we), 32'd0);
    check({tag, "_glb_we"},      32'(glb_we), 32'd0);
    check({tag, "_dram_addr"},   dram_addr, 32'd0);
    check({tag, "_dram_w_data"}, dram_w_data, 32'd0);
    check({tag, "_glb_r_addr"},  glb_r_addr, 32'd0);
    check({tag, "_glb_w_addr"},  glb_w_addr, 32'd0);
    check({tag, "_glb_w_data"},  glb_w_data, 32'd0);
  endtask

  initial begin
    int f0, g0, d0, wr0, waited;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // Stride 1, 2 channels, ifmap not a multiple of four bytes
    load_layer(5, 5, 2, 2, 3, 1, 0);
    run_layer("A"); verify_inputs("A"); verify_op("A");

    // Stride 2, odd channel count
    load_layer(7, 7, 3, 3, 3, 2, 0);
    run_layer("B"); verify_inputs("B"); verify_op("B");

    // 1x1x1 layer: 100 + 5*(-3) = 85
    load_layer(1, 1, 1, 1, 1, 1, 2);
    run_layer("E");
    check("E_glb_op_hand",  glb_mem[GLB_OP/4],   32'd85);
    check("E_dram_op_hand", dram_mem[DRAM_OP/4], 32'd85);

    // Extreme operands: (-128)*(-128) = 16384 for every output
    load_layer(4, 4, 1, 2, 1, 1, 1);
    run_layer("N");
    for (int i = 0; i < 32; i++) begin
      check($sformatf("N_glb_op[%0d]", i),  glb_mem[GLB_OP/4 + i],   32'd16384);
      check($sformatf("N_dram_op[%0d]", i), dram_mem[DRAM_OP/4 + i], 32'd16384);
    end

    // M = 0: still finishes, no opsum traffic
    load_layer(4, 4, 1, 0, 1, 1, 0);
    run_layer("Z");
    verify_inputs("Z");

    // Ten back-to-back runs with start held high throughout
    load_layer(5, 5, 2, 2, 3, 1, 0);
    clear_opsum();
    f0 = fin_cnt; g0 = gop_cnt; d0 = dwr_cnt;
    @(negedge clk); set_shape(); start = 1'b1;
    for (int run = 0; run < 10; run++) begin
      wait_finish($sformatf("R%0d", run), f0 + run);
      if (run == 9) start = 1'b0;
      verify_op($sformatf("R%0d", run));
    end
    repeat (50) @(negedge clk);
    check("R_finish_pulses", fin_cnt - f0, 32'd10);
    check("R_glb_opsum_writes", gop_cnt - g0, 32'd180);
    check("R_dram_writes", dwr_cnt - d0, 32'd180);

    // Reset during COMPUTE, then a clean rerun
    load_layer(7, 7, 3, 3, 3, 2, 0);
    clear_opsum();
    g0 = gop_cnt;
    @(negedge clk); set_shape(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (gop_cnt - g0 < 3 && waited < 40000) begin @(negedge clk); waited++; end
    check("abort_reached_compute", 32'(gop_cnt - g0 >= 3), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    wr0 = gop_cnt + dwr_cnt;
    repeat (4) @(negedge clk);
    check("abort_no_writes", gop_cnt + dwr_cnt, wr0);
    check("abort_partial", 32'(gop_cnt - g0 < n_out()), 32'd1);
    rst = 1'b1;
    run_layer("B2"); verify_inputs("B2"); verify_op("B2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
